// File: rtl/clock_divider_ctrl.sv
// Derived-clock controller: drives value/strobe pairs for a downstream clock primitive,
// with handshaked half-period reconfiguration and glitch-safe gating. Optional rising-edge
// statistics counter enabled by defining CLOCK_DIVIDER_CTRL_STATS_EN.
module clock_divider_ctrl #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DEF_HI    = 1,
   parameter int unsigned DEF_LO    = 1,
   parameter bit          INIT_GATE = 1'b1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             run,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [WIDTH-1:0] cfg_hi,
   input  logic [WIDTH-1:0] cfg_lo,
   input  logic             gate_valid,
   output logic             gate_ready,
   input  logic             gate_val,
   output logic             clk_val,
   output logic             clk_val_en,
   output logic             cond_val,
   output logic             cond_val_en,
   output logic             running,
   output logic [31:0]      edge_count
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOW  = 2'd1;
   localparam logic [1:0] S_HIGH = 2'd2;

   // Half-periods are held as (length - 1) so they load straight into the down-counter.
   localparam logic [WIDTH-1:0] DEF_HI_M1 = (DEF_HI == 0) ? '0 : WIDTH'(DEF_HI - 1);
   localparam logic [WIDTH-1:0] DEF_LO_M1 = (DEF_LO == 0) ? '0 : WIDTH'(DEF_LO - 1);

   function automatic logic [WIDTH-1:0] len_m1(input logic [WIDTH-1:0] v);
      return (v == '0) ? '0 : v - WIDTH'(1);
   endfunction

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_m1_q, hi_m1_d, lo_m1_q, lo_m1_d;
   logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
   logic             cfg_ready_q, cfg_ready_d;
   logic             gate_ready_q, gate_ready_d;
   logic             gate_pend_val_q, gate_pend_val_d;
   logic             clk_val_q, clk_val_d, clk_val_en_q, clk_val_en_d;
   logic             cond_val_q, cond_val_d, cond_val_en_q, cond_val_en_d;
   logic             running_q, running_d;
   logic [WIDTH-1:0] lo_use;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q         <= S_IDLE;
         cnt_q           <= '0;
         hi_m1_q         <= DEF_HI_M1;
         lo_m1_q         <= DEF_LO_M1;
         pend_hi_q       <= '0;
         pend_lo_q       <= '0;
         cfg_ready_q     <= 1'b1;
         gate_ready_q    <= 1'b1;
         gate_pend_val_q <= 1'b0;
         clk_val_q       <= 1'b0;
         clk_val_en_q    <= 1'b0;
         cond_val_q      <= INIT_GATE;
         cond_val_en_q   <= 1'b0;
         running_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         hi_m1_q         <= hi_m1_d;
         lo_m1_q         <= lo_m1_d;
         pend_hi_q       <= pend_hi_d;
         pend_lo_q       <= pend_lo_d;
         cfg_ready_q     <= cfg_ready_d;
         gate_ready_q    <= gate_ready_d;
         gate_pend_val_q <= gate_pend_val_d;
         clk_val_q       <= clk_val_d;
         clk_val_en_q    <= clk_val_en_d;
         cond_val_q      <= cond_val_d;
         cond_val_en_q   <= cond_val_en_d;
         running_q       <= running_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      hi_m1_d         = hi_m1_q;
      lo_m1_d         = lo_m1_q;
      pend_hi_d       = pend_hi_q;
      pend_lo_d       = pend_lo_q;
      cfg_ready_d     = cfg_ready_q;
      gate_ready_d    = gate_ready_q;
      gate_pend_val_d = gate_pend_val_q;
      clk_val_d       = clk_val_q;
      clk_val_en_d    = 1'b0;
      cond_val_d      = cond_val_q;
      cond_val_en_d   = 1'b0;
      lo_use          = lo_m1_q;

      if (cfg_valid && cfg_ready_q) begin
         cfg_ready_d = 1'b0;
         pend_hi_d   = len_m1(cfg_hi);
         pend_lo_d   = len_m1(cfg_lo);
      end
      if (gate_valid && gate_ready_q) begin
         gate_ready_d    = 1'b0;
         gate_pend_val_d = gate_val;
      end

      case (state_q)
         S_IDLE: begin
            if (!cfg_ready_q) begin
               hi_m1_d     = pend_hi_q;
               lo_m1_d     = pend_lo_q;
               lo_use      = pend_lo_q;
               cfg_ready_d = 1'b1;
            end
            if (run) begin
               state_d = S_LOW;
               cnt_d   = lo_use;
            end
         end
         S_LOW: begin
            // Stopping while low never produces a rising edge.
            if (!run) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - WIDTH'(1);
            end else begin
               state_d      = S_HIGH;
               cnt_d        = hi_m1_q;
               clk_val_d    = 1'b1;
               clk_val_en_d = 1'b1;
            end
         end
         S_HIGH: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - WIDTH'(1);
            end else begin
               clk_val_d    = 1'b0;
               clk_val_en_d = 1'b1;
               if (!cfg_ready_q) begin
                  hi_m1_d     = pend_hi_q;
                  lo_m1_d     = pend_lo_q;
                  lo_use      = pend_lo_q;
                  cfg_ready_d = 1'b1;
               end
               if (run) begin
                  state_d = S_LOW;
                  cnt_d   = lo_use;
               end else begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      // Gate changes only where no rising edge can be issued in the same cycle.
      if (!gate_ready_q && ((state_q == S_IDLE) || ((state_q == S_LOW) && (cnt_q != '0)))) begin
         cond_val_d    = gate_pend_val_q;
         cond_val_en_d = 1'b1;
         gate_ready_d  = 1'b1;
      end

      running_d = (state_d != S_IDLE);
   end

   assign cfg_ready   = cfg_ready_q;
   assign gate_ready  = gate_ready_q;
   assign clk_val     = clk_val_q;
   assign clk_val_en  = clk_val_en_q;
   assign cond_val    = cond_val_q;
   assign cond_val_en = cond_val_en_q;
   assign running     = running_q;

`ifdef CLOCK_DIVIDER_CTRL_STATS_EN
   logic [31:0] edge_count_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         edge_count_q <= '0;
      end else if (clk_val_en_d && clk_val_d) begin
         edge_count_q <= edge_count_q + 32'd1;
      end
   end

   assign edge_count = edge_count_q;
`else
   assign edge_count = '0;
`endif

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// Directed self-checking bench for clock_divider_ctrl; expected strobe patterns are
// hand-derived cycle by cycle from the phase lengths.
module tb_clock_divider_ctrl;

   localparam int unsigned W = 8;

   logic         CLK = 1'b0;
   logic         RST;
   logic         run;
   logic         cfg_valid;
   logic         cfg_ready;
   logic [W-1:0] cfg_hi;
   logic [W-1:0] cfg_lo;
   logic         gate_valid;
   logic         gate_ready;
   logic         gate_val;
   logic         clk_val;
   logic         clk_val_en;
   logic         cond_val;
   logic         cond_val_en;
   logic         running;
   logic [31:0]  edge_count;

   int checks = 0;
   int errors = 0;

`ifdef CLOCK_DIVIDER_CTRL_STATS_EN
   localparam logic [31:0] EXP_EDGES = 32'd10;
`else
   localparam logic [31:0] EXP_EDGES = 32'd0;
`endif

   // {clk_val_en, clk_val, cond_val_en, cond_val} for the gate/rise collision case
   logic [3:0] exp_gate [1:12] = '{4'b0001, 4'b0001, 4'b0001, 4'b1101, 4'b0101, 4'b0101,
                                   4'b0101, 4'b1001, 4'b0010, 4'b0000, 4'b0000, 4'b1100};
   // {clk_val_en, clk_val, cfg_ready} for reconfiguration during HIGH
   logic [2:0] exp_recfg [1:13] = '{3'b001, 3'b001, 3'b111, 3'b010, 3'b010, 3'b010, 3'b010,
                                    3'b101, 3'b001, 3'b111, 3'b101, 3'b001, 3'b111};
   // {clk_val_en, clk_val, running} for run dropped mid-HIGH
   logic [2:0] exp_stop [1:12] = '{3'b111, 3'b011, 3'b011, 3'b011, 3'b011, 3'b100,
                                   3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};

   clock_divider_ctrl #(.WIDTH(W), .DEF_HI(1), .DEF_LO(1), .INIT_GATE(1'b1)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .run        (run),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_hi     (cfg_hi),
      .cfg_lo     (cfg_lo),
      .gate_valid (gate_valid),
      .gate_ready (gate_ready),
      .gate_val   (gate_val),
      .clk_val    (clk_val),
      .clk_val_en (clk_val_en),
      .cond_val   (cond_val),
      .cond_val_en(cond_val_en),
      .running    (running),
      .edge_count (edge_count)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b1; run = 1'b0; cfg_valid = 1'b0; gate_valid = 1'b0;
      tick();
      tick();
      RST = 1'b0;
   endtask

   task automatic do_cfg(input logic [W-1:0] hi, input logic [W-1:0] lo);
      cfg_hi = hi; cfg_lo = lo; cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      tick();
   endtask

   initial begin
      RST = 1'b1; run = 1'b0; cfg_valid = 1'b0; gate_valid = 1'b0;
      gate_val = 1'b0; cfg_hi = '0; cfg_lo = '0;

      // Reset state
      do_reset();
      check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
      check("rst_gate_ready", 32'(gate_ready), 32'd1);
      check("rst_clk", 32'({clk_val_en, clk_val}), 32'd0);
      check("rst_cond", 32'({cond_val_en, cond_val}), 32'd1);
      check("rst_running", 32'(running), 32'd0);
      check("rst_edges", edge_count, 32'd0);

      // Simultaneous cfg and gate requests while idle, then hi=2 lo=3
      cfg_hi = 8'd2; cfg_lo = 8'd3; cfg_valid = 1'b1;
      gate_val = 1'b0; gate_valid = 1'b1;
      tick();
      cfg_valid = 1'b0; gate_valid = 1'b0;
      check("both_accepted", 32'({cfg_ready, gate_ready}), 32'd0);
      tick();
      check("both_applied", 32'({cfg_ready, gate_ready}), 32'b11);
      check("idle_gate", 32'({cond_val_en, cond_val}), 32'b10);
      run = 1'b1;
      tick();
      check("enter_low", 32'({running, clk_val_en}), 32'b10);
      for (int k = 1; k <= 15; k++) begin
         tick();
         check($sformatf("p5[%0d]", k), 32'({clk_val_en, clk_val}),
               32'({(k % 5 == 3) || (k % 5 == 0), (k % 5 == 3) || (k % 5 == 4)}));
      end

      // Zero half-periods behave as 1/1
      do_reset();
      do_cfg(8'd0, 8'd0);
      run = 1'b1;
      tick();
      for (int k = 1; k <= 8; k++) begin
         tick();
         check($sformatf("p2[%0d]", k), 32'({clk_val_en, clk_val}), 32'({1'b1, k[0]}));
      end

      // Gate request pending in the LOW cnt==0 cycle is deferred past the high phase
      do_reset();
      do_cfg(8'd4, 8'd4);
      run = 1'b1;
      tick();
      for (int k = 1; k <= 12; k++) begin
         gate_val   = 1'b0;
         gate_valid = (k == 3);
         tick();
         gate_valid = 1'b0;
         check($sformatf("gate[%0d]", k), 32'({clk_val_en, clk_val, cond_val_en, cond_val}),
               32'(exp_gate[k]));
      end

      // New hi=1 lo=2 requested during a hi=5 high phase
      do_reset();
      do_cfg(8'd5, 8'd3);
      run = 1'b1;
      tick();
      for (int k = 1; k <= 13; k++) begin
         cfg_hi = 8'd1; cfg_lo = 8'd2;
         cfg_valid = (k == 4);
         tick();
         cfg_valid = 1'b0;
         check($sformatf("recfg[%0d]", k), 32'({clk_val_en, clk_val, cfg_ready}),
               32'(exp_recfg[k]));
      end

      // run dropped with HIGH cnt=3 finishes the high phase then idles
      do_reset();
      do_cfg(8'd5, 8'd1);
      run = 1'b1;
      tick();
      for (int k = 1; k <= 12; k++) begin
         if (k == 3) run = 1'b0;
         tick();
         check($sformatf("stop[%0d]", k), 32'({clk_val_en, clk_val, running}),
               32'(exp_stop[k]));
      end

      // Ten full 1/1 periods, then reset mid-run with no falling strobe
      do_reset();
      run = 1'b1;
      tick();
      for (int k = 1; k <= 20; k++) tick();
      check("edges10", edge_count, EXP_EDGES);
      tick();
      check("pre_rst_rise", 32'({clk_val_en, clk_val}), 32'b11);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      check("rst_abort_clk", 32'({clk_val_en, clk_val}), 32'd0);
      check("rst_abort_run", 32'(running), 32'd0);
      check("rst_edges0", edge_count, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
